// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- dual-issue pipeline control unit.
//
// Drives the flush, stall, redirect and forwarding-select signals for two
// issue lanes (lane 2 is the younger lane). A taken branch or a JAL raises
// a one-cycle redirect pulse one cycle after it is seen. The unit then holds
// a FLUSH state for FLUSH_CYCLES cycles. A load scoreboard stalls decode
// while a source register waits on an outstanding load. Combinational
// forwarding selects each decode source from the youngest matching stage.
//
// Parameters : AW (PC width), RW (register index width),
//              FLUSH_CYCLES (cycles held in FLUSH, >=1),
//              LSU_DEPTH (max outstanding loads, >=1)
// Inputs     : clk, rst (synchronous, active high), fifo_full, buffer_full,
//              jal_*/br1_*/br2_* redirect sources, dec*/ex*/wb* register
//              indices and write enables, lsu_issue/lsu_rd,
//              lsu_done/lsu_done_rd
// Outputs    : stop_fetch, redirect, redirect_addr, fifo/buffer flush and
//              stall, dec1/dec2/ex flush, dec2_hold, fwd1a/fwd1b/fwd2a/fwd2b
//              (0 RF, 1 ex1, 2 ex2, 3 wb1, 4 wb2),
//              state (00 RUN, 01 FLUSH, 10 LSU_FULL)
// Option     : define PIPE_CTRL_PERF_EN to add the perf_stall_cnt and
//              perf_flush_cnt 32-bit counters.
module pipeline_ctrl #(
   parameter int AW           = 32,
   parameter int RW           = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int LSU_DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_full,
   input  logic          buffer_full,
   input  logic          jal_valid,
   input  logic [AW-1:0] jal_addr,
   input  logic          br1_valid,
   input  logic          br1_taken,
   input  logic [AW-1:0] br1_addr,
   input  logic          br2_valid,
   input  logic          br2_taken,
   input  logic [AW-1:0] br2_addr,
   input  logic [RW-1:0] dec1_rs1,
   input  logic [RW-1:0] dec1_rs2,
   input  logic [RW-1:0] dec2_rs1,
   input  logic [RW-1:0] dec2_rs2,
   input  logic [RW-1:0] dec1_rd,
   input  logic          dec1_we,
   input  logic [RW-1:0] ex1_rd,
   input  logic [RW-1:0] ex2_rd,
   input  logic [RW-1:0] wb1_rd,
   input  logic [RW-1:0] wb2_rd,
   input  logic          ex1_we,
   input  logic          ex2_we,
   input  logic          wb1_we,
   input  logic          wb2_we,
   input  logic          lsu_issue,
   input  logic [RW-1:0] lsu_rd,
   input  logic          lsu_done,
   input  logic [RW-1:0] lsu_done_rd,
   output logic          stop_fetch,
   output logic          redirect,
   output logic [AW-1:0] redirect_addr,
   output logic          fifo_flush,
   output logic          fifo_stall,
   output logic          buffer_flush,
   output logic          buffer_stall,
   output logic          dec1_flush,
   output logic          dec2_flush,
   output logic          ex_flush,
   output logic          dec2_hold,
   output logic [2:0]    fwd1a,
   output logic [2:0]    fwd1b,
   output logic [2:0]    fwd2a,
   output logic [2:0]    fwd2b,
   output logic [1:0]    state
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_flush_cnt
`endif
);

   localparam int NREG = 2**RW;
   localparam int CW   = $clog2(LSU_DEPTH + 1);
   localparam int FW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(LSU_DEPTH);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

   localparam logic [2:0] FWD_RF  = 3'd0;
   localparam logic [2:0] FWD_EX1 = 3'd1;
   localparam logic [2:0] FWD_EX2 = 3'd2;
   localparam logic [2:0] FWD_WB1 = 3'd3;
   localparam logic [2:0] FWD_WB2 = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_FLUSH    = 2'b01,
      ST_LSU_FULL = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;        // flush cycles left after this one
   logic            kind_br_q, kind_br_d;  // flush also kills decode
   logic            kind_ex_q, kind_ex_d;  // flush also kills execute
   logic            redirect_q, redirect_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic br1_hit, br2_hit, evt;
   logic flushing, lsu_full, src_busy_any;

   assign br1_hit  = br1_valid & br1_taken;
   assign br2_hit  = br2_valid & br2_taken;
   assign evt      = br1_hit | br2_hit | jal_valid;
   assign flushing = (state_q == ST_FLUSH);
   assign lsu_full = (cnt_q == DEPTH_C);

   function automatic logic src_busy(input logic [RW-1:0] src);
      return (src != '0) && busy_q[src];
   endfunction

   // Youngest matching stage wins: ex2 > ex1 > wb2 > wb1.
   function automatic logic [2:0] fwd_sel(input logic [RW-1:0] src);
      logic [2:0] sel;
      sel = FWD_RF;
      if (src != '0) begin
         if (ex2_we && ex2_rd == src)      sel = FWD_EX2;
         else if (ex1_we && ex1_rd == src) sel = FWD_EX1;
         else if (wb2_we && wb2_rd == src) sel = FWD_WB2;
         else if (wb1_we && wb1_rd == src) sel = FWD_WB1;
      end
      return sel;
   endfunction

   assign src_busy_any = src_busy(dec1_rs1) | src_busy(dec1_rs2) |
                         src_busy(dec2_rs1) | src_busy(dec2_rs2);

   // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (lsu_done)                 busy_d[lsu_done_rd] = 1'b0;
      // Issue is applied after done so a same-register set/clear keeps the bit set.
      if (lsu_issue && lsu_rd != '0) busy_d[lsu_rd]     = 1'b1;

      cnt_d = cnt_q;
      if (lsu_issue && !lsu_done && cnt_q != DEPTH_C)  cnt_d = cnt_q + CW'(1);
      else if (!lsu_issue && lsu_done && cnt_q != '0)  cnt_d = cnt_q - CW'(1);
   end

   // Next-state logic. A redirect always (re)enters FLUSH, including from FLUSH itself.
   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      kind_br_d  = kind_br_q;
      kind_ex_d  = kind_ex_q;
      redirect_d = 1'b0;
      raddr_d    = raddr_q;
      if (evt) begin
         state_d    = ST_FLUSH;
         fcnt_d     = FLUSH_LOAD;
         redirect_d = 1'b1;
         kind_br_d  = br1_hit | br2_hit;
         kind_ex_d  = br1_hit;
         raddr_d    = br1_hit ? br1_addr : (br2_hit ? br2_addr : jal_addr);
      end else begin
         case (state_q)
            ST_FLUSH: begin
               if (fcnt_q == '0) state_d = (cnt_d == DEPTH_C) ? ST_LSU_FULL : ST_RUN;
               else              fcnt_d  = fcnt_q - FW'(1);
            end
            default: state_d = (cnt_d == DEPTH_C) ? ST_LSU_FULL : ST_RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         fcnt_q     <= '0;
         kind_br_q  <= 1'b0;
         kind_ex_q  <= 1'b0;
         redirect_q <= 1'b0;
         raddr_q    <= '0;
         // NOTE: the busy vector is a register file that must start clear, so it is reset unlike a data RAM.
         busy_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         kind_br_q  <= kind_br_d;
         kind_ex_q  <= kind_ex_d;
         redirect_q <= redirect_d;
         raddr_q    <= raddr_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
      end
   end

   // Outputs are forced to zero while rst is high, including the cycle before the first reset edge.
   always_comb begin
      stop_fetch    = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      fifo_flush    = 1'b0;
      fifo_stall    = 1'b0;
      buffer_flush  = 1'b0;
      buffer_stall  = 1'b0;
      dec1_flush    = 1'b0;
      dec2_flush    = 1'b0;
      ex_flush      = 1'b0;
      dec2_hold     = 1'b0;
      fwd1a         = FWD_RF;
      fwd1b         = FWD_RF;
      fwd2a         = FWD_RF;
      fwd2b         = FWD_RF;
      state         = ST_RUN;
      if (!rst) begin
         redirect      = redirect_q;
         redirect_addr = raddr_q;
         state         = state_q;
         fifo_flush    = flushing;
         buffer_flush  = flushing;
         dec1_flush    = flushing & kind_br_q;
         dec2_flush    = flushing & kind_br_q;
         ex_flush      = flushing & kind_ex_q;
         stop_fetch    = fifo_full | flushing;
         buffer_stall  = src_busy_any | lsu_full;
         fifo_stall    = src_busy_any | lsu_full | buffer_full;
         dec2_hold     = dec1_we && dec1_rd != '0 &&
                         (dec2_rs1 == dec1_rd || dec2_rs2 == dec1_rd);
         fwd1a         = fwd_sel(dec1_rs1);
         fwd1b         = fwd_sel(dec1_rs2);
         fwd2a         = fwd_sel(dec2_rs1);
         fwd2b         = fwd_sel(dec2_rs2);
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + 32'(buffer_stall);
         perf_flush_cnt <= perf_flush_cnt + 32'(redirect_q);
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vectors, a cycle-level
// behavioural model, one compare process on every falling edge, and
// hand-computed literal expectations at key points.
module tb_pipeline_ctrl;

   localparam int AW    = 32;
   localparam int RW    = 5;
   localparam int FC    = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          fifo_full, buffer_full;
   logic          jal_valid, br1_valid, br1_taken, br2_valid, br2_taken;
   logic [AW-1:0] jal_addr, br1_addr, br2_addr;
   logic [RW-1:0] dec1_rs1, dec1_rs2, dec2_rs1, dec2_rs2, dec1_rd;
   logic          dec1_we;
   logic [RW-1:0] ex1_rd, ex2_rd, wb1_rd, wb2_rd;
   logic          ex1_we, ex2_we, wb1_we, wb2_we;
   logic          lsu_issue, lsu_done;
   logic [RW-1:0] lsu_rd, lsu_done_rd;

   logic          stop_fetch, redirect;
   logic [AW-1:0] redirect_addr;
   logic          fifo_flush, fifo_stall, buffer_flush, buffer_stall;
   logic          dec1_flush, dec2_flush, ex_flush, dec2_hold;
   logic [2:0]    fwd1a, fwd1b, fwd2a, fwd2b;
   logic [1:0]    state;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

   pipeline_ctrl #(.AW(AW), .RW(RW), .FLUSH_CYCLES(FC), .LSU_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .fifo_full(fifo_full), .buffer_full(buffer_full),
      .jal_valid(jal_valid), .jal_addr(jal_addr),
      .br1_valid(br1_valid), .br1_taken(br1_taken), .br1_addr(br1_addr),
      .br2_valid(br2_valid), .br2_taken(br2_taken), .br2_addr(br2_addr),
      .dec1_rs1(dec1_rs1), .dec1_rs2(dec1_rs2), .dec2_rs1(dec2_rs1), .dec2_rs2(dec2_rs2),
      .dec1_rd(dec1_rd), .dec1_we(dec1_we),
      .ex1_rd(ex1_rd), .ex2_rd(ex2_rd), .wb1_rd(wb1_rd), .wb2_rd(wb2_rd),
      .ex1_we(ex1_we), .ex2_we(ex2_we), .wb1_we(wb1_we), .wb2_we(wb2_we),
      .lsu_issue(lsu_issue), .lsu_rd(lsu_rd), .lsu_done(lsu_done), .lsu_done_rd(lsu_done_rd),
      .stop_fetch(stop_fetch), .redirect(redirect), .redirect_addr(redirect_addr),
      .fifo_flush(fifo_flush), .fifo_stall(fifo_stall),
      .buffer_flush(buffer_flush), .buffer_stall(buffer_stall),
      .dec1_flush(dec1_flush), .dec2_flush(dec2_flush), .ex_flush(ex_flush),
      .dec2_hold(dec2_hold), .fwd1a(fwd1a), .fwd1b(fwd1b), .fwd2a(fwd2a), .fwd2b(fwd2b),
      .state(state)
`ifdef PIPE_CTRL_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Flush is tracked as a window of absolute cycle numbers; the redirect
   // pulse is the first cycle of that window.
   bit            m_busy[2**RW];
   int            m_count   = 0;
   int            fl_start  = -10;
   int            fl_end    = -10;
   bit            m_br      = 0;
   bit            m_ex      = 0;
   logic [AW-1:0] m_addr    = '0;
   int            cyc       = 0;
   bit            armed     = 0;
   bit            e_bstall  = 0;
   bit            e_red     = 0;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   m_stall_cnt = '0;
   logic [31:0]   m_flush_cnt = '0;
`endif

   function automatic logic [2:0] m_fwd(input logic [RW-1:0] src);
      logic [RW-1:0] rds[4];
      logic          wes[4];
      logic [2:0]    codes[4];
      rds   = '{ex2_rd, ex1_rd, wb2_rd, wb1_rd};
      wes   = '{ex2_we, ex1_we, wb2_we, wb1_we};
      codes = '{3'd2, 3'd1, 3'd4, 3'd3};
      if (src == 0) return 3'd0;
      for (int i = 0; i < 4; i++)
         if (wes[i] && rds[i] != 0 && rds[i] == src) return codes[i];
      return 3'd0;
   endfunction

   function automatic bit m_src_busy(input logic [RW-1:0] src);
      return src != 0 && m_busy[src];
   endfunction

   always @(posedge clk) begin : model
      int n;
      n = cyc;
`ifdef PIPE_CTRL_PERF_EN
      if (rst) begin
         m_stall_cnt = '0;
         m_flush_cnt = '0;
      end else begin
         m_stall_cnt = m_stall_cnt + 32'(e_bstall);
         m_flush_cnt = m_flush_cnt + 32'(e_red);
      end
`endif
      if (rst) begin
         for (int i = 0; i < 2**RW; i++) m_busy[i] = 0;
         m_count  = 0;
         fl_start = -10;
         fl_end   = -10;
         m_addr   = '0;
         m_br     = 0;
         m_ex     = 0;
      end else begin
         if (br1_valid && br1_taken) begin
            m_addr = br1_addr; m_br = 1; m_ex = 1;
         end else if (br2_valid && br2_taken) begin
            m_addr = br2_addr; m_br = 1; m_ex = 0;
         end else if (jal_valid) begin
            m_addr = jal_addr; m_br = 0; m_ex = 0;
         end
         if ((br1_valid && br1_taken) || (br2_valid && br2_taken) || jal_valid) begin
            fl_start = n + 1;
            fl_end   = n + FC;
         end
         if (lsu_done) m_busy[lsu_done_rd] = 0;
         if (lsu_issue && lsu_rd != 0) m_busy[lsu_rd] = 1;
         m_count = m_count + int'(lsu_issue) - int'(lsu_done);
         if (m_count < 0)     m_count = 0;
         if (m_count > DEPTH) m_count = DEPTH;
      end
      cyc   = n + 1;
      armed = 1;
   end

   always @(negedge clk) begin : compare
      bit in_fl, full, anyb;
      logic [1:0] e_state;
      if (armed) begin
         in_fl = !rst && cyc >= fl_start && cyc <= fl_end;
         full  = (m_count == DEPTH);
         anyb  = m_src_busy(dec1_rs1) || m_src_busy(dec1_rs2) ||
                 m_src_busy(dec2_rs1) || m_src_busy(dec2_rs2);
         e_bstall = !rst && (anyb || full);
         e_red    = !rst && cyc == fl_start;
         e_state  = rst ? 2'd0 : (in_fl ? 2'd1 : (full ? 2'd2 : 2'd0));
         check("m_state",        state,        e_state);
         check("m_redirect",     redirect,     e_red);
         if (e_red) check("m_redirect_addr", redirect_addr, m_addr);
         check("m_stop_fetch",   stop_fetch,   !rst && (fifo_full || in_fl));
         check("m_fifo_flush",   fifo_flush,   in_fl);
         check("m_buffer_flush", buffer_flush, in_fl);
         check("m_dec1_flush",   dec1_flush,   in_fl && m_br);
         check("m_dec2_flush",   dec2_flush,   in_fl && m_br);
         check("m_ex_flush",     ex_flush,     in_fl && m_ex);
         check("m_buffer_stall", buffer_stall, e_bstall);
         check("m_fifo_stall",   fifo_stall,   !rst && (anyb || full || buffer_full));
         check("m_dec2_hold",    dec2_hold,    !rst && dec1_we && dec1_rd != 0 &&
                                               (dec2_rs1 == dec1_rd || dec2_rs2 == dec1_rd));
         check("m_fwd1a", fwd1a, rst ? 3'd0 : m_fwd(dec1_rs1));
         check("m_fwd1b", fwd1b, rst ? 3'd0 : m_fwd(dec1_rs2));
         check("m_fwd2a", fwd2a, rst ? 3'd0 : m_fwd(dec2_rs1));
         check("m_fwd2b", fwd2b, rst ? 3'd0 : m_fwd(dec2_rs2));
`ifdef PIPE_CTRL_PERF_EN
         check("m_perf_stall", perf_stall_cnt, m_stall_cnt);
         check("m_perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic idle();
      fifo_full = 0; buffer_full = 0;
      jal_valid = 0; br1_valid = 0; br1_taken = 0; br2_valid = 0; br2_taken = 0;
      jal_addr = '0; br1_addr = '0; br2_addr = '0;
      dec1_rs1 = '0; dec1_rs2 = '0; dec2_rs1 = '0; dec2_rs2 = '0; dec1_rd = '0; dec1_we = 0;
      ex1_rd = '0; ex2_rd = '0; wb1_rd = '0; wb2_rd = '0;
      ex1_we = 0; ex2_we = 0; wb1_we = 0; wb2_we = 0;
      lsu_issue = 0; lsu_rd = '0; lsu_done = 0; lsu_done_rd = '0;
   endtask

   // events_on: allow occasional redirects/loads; src_max bounds register indices
   task automatic rand_inputs(input bit events_on, input int src_max);
      fifo_full = 1'($urandom_range(0, 1)); buffer_full = 1'($urandom_range(0, 1));
      br1_valid = 1'($urandom_range(0, 1)); br2_valid = 1'($urandom_range(0, 1));
      br1_taken = events_on ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
      br2_taken = events_on ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
      jal_valid = events_on ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
      jal_addr = $urandom; br1_addr = $urandom; br2_addr = $urandom;
      dec1_rs1 = RW'($urandom_range(0, src_max)); dec1_rs2 = RW'($urandom_range(0, src_max));
      dec2_rs1 = RW'($urandom_range(0, src_max)); dec2_rs2 = RW'($urandom_range(0, src_max));
      dec1_rd  = RW'($urandom_range(0, src_max)); dec1_we  = 1'($urandom_range(0, 1));
      ex1_rd = RW'($urandom_range(0, src_max)); ex2_rd = RW'($urandom_range(0, src_max));
      wb1_rd = RW'($urandom_range(0, src_max)); wb2_rd = RW'($urandom_range(0, src_max));
      ex1_we = 1'($urandom_range(0, 1)); ex2_we = 1'($urandom_range(0, 1));
      wb1_we = 1'($urandom_range(0, 1)); wb2_we = 1'($urandom_range(0, 1));
      lsu_issue   = events_on ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      lsu_done    = events_on ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      lsu_rd      = RW'($urandom_range(0, src_max));
      lsu_done_rd = RW'($urandom_range(0, src_max));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      // Reset with random inputs for two edges
      rst = 1;
      rand_inputs(0, 31);
      tick();
      rand_inputs(0, 31);
      mid();
      check("rst_state",    state,        0);
      check("rst_redirect", redirect,     0);
      check("rst_addr",     redirect_addr, 0);
      check("rst_stall",    buffer_stall, 0);
      check("rst_stop",     stop_fetch,   0);
      check("rst_fwd1a",    fwd1a,        0);
      check("rst_hold",     dec2_hold,    0);
      tick();
      rst = 0;
      idle();
      tick();

      // Simultaneous br1/br2/jal: br1 wins, full flush including execute
      br1_valid = 1; br1_taken = 1; br1_addr = 'h100;
      br2_valid = 1; br2_taken = 1; br2_addr = 'h200;
      jal_valid = 1; jal_addr = 'h40;
      tick(); idle();
      mid();
      check("simul_redirect", redirect,      1);
      check("simul_addr",     redirect_addr, 'h100);
      check("simul_ex_flush", ex_flush,      1);
      check("simul_state_a",  state,         1);
      tick(); mid();
      check("simul_state_b",  state,         1);
      check("simul_pulse",    redirect,      0);
      tick(); mid();
      check("simul_state_run", state,        0);
      check("simul_flush_off", fifo_flush,   0);

      // JAL only: fetch-side flush only
      jal_valid = 1; jal_addr = 'h40;
      tick(); idle();
      mid();
      check("jal_addr",         redirect_addr, 'h40);
      check("jal_fifo_flush",   fifo_flush,    1);
      check("jal_buffer_flush", buffer_flush,  1);
      check("jal_dec1_flush",   dec1_flush,    0);
      check("jal_ex_flush",     ex_flush,      0);
      tick(); tick(); tick();

      // br2 (br1 resolved not-taken), then JAL during the flush
      br1_valid = 1; br1_taken = 0; br1_addr = 'h999;
      br2_valid = 1; br2_taken = 1; br2_addr = 'h300;
      tick(); idle();
      jal_valid = 1; jal_addr = 'h80;
      mid();
      check("br2_addr",       redirect_addr, 'h300);
      check("br2_ex_flush",   ex_flush,      0);
      check("br2_dec2_flush", dec2_flush,    1);
      tick(); idle();
      mid();
      check("reflush_addr",   redirect_addr, 'h80);
      check("reflush_pulse",  redirect,      1);
      check("reflush_dec1",   dec1_flush,    0);
      tick(); mid();
      check("reflush_state",  state,         1);
      tick(); mid();
      check("reflush_run",    state,         0);

      // Load dependency on r7
      lsu_issue = 1; lsu_rd = 7;
      tick(); lsu_issue = 0; dec1_rs1 = 7;
      mid();
      check("ld_stall",      buffer_stall, 1);
      check("ld_fifo_stall", fifo_stall,   1);
      tick(); lsu_done = 1; lsu_done_rd = 7;
      mid();
      check("ld_stall_done_cycle", buffer_stall, 1);
      tick(); lsu_done = 0;
      mid();
      check("ld_stall_clear", buffer_stall, 0);
      check("ld_fifo_clear",  fifo_stall,   0);
      dec1_rs1 = 0; buffer_full = 1;
      tick(); mid();
      check("bfull_fifo_stall", fifo_stall,   1);
      check("bfull_buf_stall",  buffer_stall, 0);
      buffer_full = 0;

      // Same-register set and clear in one cycle: set wins
      lsu_issue = 1; lsu_rd = 9;
      tick(); lsu_done = 1; lsu_done_rd = 9;
      tick(); lsu_issue = 0; lsu_done = 0; dec2_rs2 = 9;
      mid();
      check("set_wins", buffer_stall, 1);
      lsu_done = 1; lsu_done_rd = 9;
      tick(); lsu_done = 0;
      mid();
      check("set_wins_clear", buffer_stall, 0);
      dec2_rs2 = 0;
      lsu_issue = 1; lsu_rd = 0;
      tick(); lsu_issue = 0; lsu_done = 1; lsu_done_rd = 0;
      tick(); lsu_done = 0;

      // Load depth and saturation
      for (int i = 1; i <= DEPTH; i++) begin
         lsu_issue = 1; lsu_rd = RW'(i);
         tick();
      end
      lsu_rd = 5;
      mid();
      check("full_state", state,        2);
      check("full_stall", buffer_stall, 1);
      tick(); lsu_issue = 0;
      mid();
      check("full_sat_state", state, 2);
      br1_valid = 1; br1_taken = 1; br1_addr = 'h500;
      tick(); idle();
      mid();
      check("full_flush_prio", state, 1);
      tick(); tick(); mid();
      check("full_after_flush", state, 2);
      lsu_done = 1; lsu_done_rd = 1;
      tick(); lsu_done = 0;
      mid();
      check("one_done_state", state,        0);
      check("one_done_stall", buffer_stall, 0);
      for (int i = 2; i <= 5; i++) begin
         lsu_done = 1; lsu_done_rd = RW'(i);
         tick();
      end
      lsu_done = 1; lsu_done_rd = 0;
      tick(); lsu_done = 0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         lsu_issue = 1; lsu_rd = 0;
         tick();
      end
      lsu_issue = 0;
      mid();
      check("no_underflow_state", state, 0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         lsu_done = 1; lsu_done_rd = 0;
         tick();
      end
      lsu_done = 0;

      // Forwarding priority and intra-pair hold
      ex1_rd = 3; ex2_rd = 3; wb1_rd = 3;
      ex1_we = 1; ex2_we = 1; wb1_we = 1;
      dec1_rs2 = 3;
      mid();
      check("fwd_ex2", fwd1b, 2);
      ex2_we = 0; #1;
      check("fwd_ex1", fwd1b, 1);
      dec1_rs2 = 0; #1;
      check("fwd_r0", fwd1b, 0);
      ex1_we = 0; wb2_rd = 3; wb2_we = 1; dec2_rs1 = 3; #1;
      check("fwd_wb2", fwd2a, 4);
      wb2_we = 0; dec1_rs1 = 3; #1;
      check("fwd_wb1", fwd1a, 3);
      dec1_rd = 5; dec1_we = 1; dec2_rs2 = 5; #1;
      check("hold_on", dec2_hold, 1);
      dec1_rd = 0; dec2_rs2 = 0; #1;
      check("hold_r0", dec2_hold, 0);
      tick(); idle();

      // Reset mid-flush with a load outstanding
      lsu_issue = 1; lsu_rd = 6;
      br1_valid = 1; br1_taken = 1; br1_addr = 'h600;
      tick(); idle();
      rst = 1;
      tick(); rst = 0; dec1_rs1 = 6;
      mid();
      check("rst_mid_state", state,        0);
      check("rst_mid_stall", buffer_stall, 0);
      check("rst_mid_flush", fifo_flush,   0);
      tick(); idle();

      // Mixed traffic checked by the model
      for (int i = 0; i < 60; i++) begin
         rand_inputs(1, 7);
         tick();
      end
      idle();
      tick(); tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised successor to the dual-issue pipeline control unit.
- Generalises PC width, register-index width, flush depth and outstanding-load depth.
- Adds a registered redirect/flush state machine, a load scoreboard, and an intra-pair dependency hold.
- Sits beside fetch/decode/execute and drives all flush, stall, redirect and forwarding-select signals for lanes 1 and 2 (lane 2 is the younger lane).

Parameters:
- AW, 32: PC/jump-address width.
- RW, 5: register index width; 2**RW architectural registers.
- FLUSH_CYCLES, 2: cycles the flush state is held after a redirect (≥1).
- LSU_DEPTH, 4: maximum outstanding loads (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fifo_full  in  1  instruction FIFO full
- buffer_full  in  1  issue buffer full
- jal_valid  in  1  JAL decoded
- jal_addr  in  AW  JAL target
- br1_valid, br1_taken  in  1 each  lane-1 branch resolved / taken
- br1_addr  in  AW  lane-1 target
- br2_valid, br2_taken  in  1 each  lane-2 branch resolved / taken
- br2_addr  in  AW  lane-2 target
- dec1_rs1, dec1_rs2, dec2_rs1, dec2_rs2  in  RW each  decode source registers
- dec1_rd  in  RW  lane-1 decode destination
- dec1_we  in  1  lane-1 decode writes rd
- ex1_rd, ex2_rd, wb1_rd, wb2_rd  in  RW each  execute/writeback destinations
- ex1_we, ex2_we, wb1_we, wb2_we  in  1 each  matching write enables
- lsu_issue  in  1  load issued
- lsu_rd  in  RW  issued load destination
- lsu_done  in  1  load returned
- lsu_done_rd  in  RW  returned load destination
- stop_fetch  out  1  fetch halt
- redirect  out  1  one-cycle PC redirect pulse
- redirect_addr  out  AW  redirect target
- fifo_flush, fifo_stall  out  1 each
- buffer_flush, buffer_stall  out  1 each
- dec1_flush, dec2_flush, ex_flush  out  1 each
- dec2_hold  out  1  lane 2 held for intra-pair RAW
- fwd1a, fwd1b, fwd2a, fwd2b  out  3 each  forwarding selects: 0 = RF, 1 = ex1, 2 = ex2, 3 = wb1, 4 = wb2
- state  out  2  00 RUN, 01 FLUSH, 10 LSU_FULL

Behaviour:
- Reset: all outputs 0, redirect_addr 0, state RUN, scoreboard clear, outstanding count 0, flush counter 0.
- Redirect priority: br1 taken > br2 taken > jal_valid.
  - br1 taken overrides br2 and jal in the same cycle.
  - br2 is honoured only when br1 is not taken.
- Redirect timing: registered. The event in cycle N gives redirect=1 and redirect_addr in cycle N+1, for exactly one cycle.
- Branch redirect (cycle N+1 onward): fifo_flush, buffer_flush, dec1_flush, dec2_flush and ex_flush are 1, with ex_flush only for a br1 redirect. State enters FLUSH and stays FLUSH_CYCLES cycles, flushes held, then returns to RUN.
- JAL redirect: flushes fifo and buffer only; decode and execute are kept.
- New redirect while in FLUSH: accepted, target updated, flush counter reloaded.
- Scoreboard: one busy bit per register.
  - Set on lsu_issue when lsu_rd ≠ 0.
  - Cleared on lsu_done for lsu_done_rd.
  - Same register set and cleared in one cycle: set wins.
  - Outstanding count is +1 on issue and -1 on done; both together leave it unchanged. It saturates at 0 and LSU_DEPTH.
- Stalls:
  - buffer_stall = any valid decode source (≠ 0) busy in the scoreboard, or count == LSU_DEPTH.
  - fifo_stall = buffer_stall | buffer_full.
  - stop_fetch = fifo_full | state==FLUSH.
  - state = LSU_FULL while count == LSU_DEPTH and not flushing; FLUSH has priority.
- Intra-pair hold: dec2_hold = dec1_we & dec1_rd ≠ 0 & (dec2_rs1 == dec1_rd | dec2_rs2 == dec1_rd).
- Forwarding: combinational, for each source.
  - Priority ex2 > ex1 > wb2 > wb1; a stage matches only when its _we is 1 and rd ≠ 0.
  - Source register 0 always selects 0.
- Reset asserted mid-flush or with loads outstanding: everything returns to its reset value on the next edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32) and perf_flush_cnt (32).
  - perf_stall_cnt increments each cycle buffer_stall=1.
  - perf_flush_cnt increments on each redirect pulse.
  - Both cleared by rst and wrap modulo 2**32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs → all outputs 0, state=00.
- Simultaneous branches: br1_taken, br1_addr=0x100, br2_taken, br2_addr=0x200, jal_valid, all in one cycle → next cycle redirect=1 with redirect_addr=0x100 and ex_flush=1; state=01 for 2 cycles, then 00.
- JAL only: jal_addr=0x40 → redirect_addr=0x40, fifo_flush=buffer_flush=1, dec1_flush=ex_flush=0.
- Load dependency: lsu_issue with lsu_rd=7, then dec1_rs1=7 → buffer_stall=1 and fifo_stall=1 until lsu_done with lsu_done_rd=7, deasserting the cycle after done.
- Load depth: 4 issues with no done → state=10, buffer_stall=1; one lsu_done → state=00.
- Forwarding: ex1_rd=ex2_rd=wb1_rd=3 with all we=1 and dec1_rs2=3 → fwd1b=2; with ex2_we=0 → fwd1b=1; dec1_rs2=0 → fwd1b=0. Also dec1_rd=5, dec1_we=1, dec2_rs2=5 → dec2_hold=1.
